// File: rtl/if_pkg.sv
// ============================================================================
// Module   : if_pkg
// Brief    : Shared constants and queue-entry type for the instruction fetch stage.
// Revision : 1.0
// ============================================================================
`default_nettype none

package if_pkg;

   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
      logic            done;
   } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/fetch_queue.sv
// ============================================================================
// Module   : fetch_queue
// Brief    : In-order circular buffer of fetch entries with push, fill-oldest-pending,
//            pop, clear and occupancy/pending counts.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fetch_queue
   import if_pkg::*;
#(
   parameter int DEPTH = 2,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            clear_i,
   input  logic            push_i,
   input  logic [XLEN-1:0] push_pc_i,
   input  logic            fill_i,
   input  logic [XLEN-1:0] fill_instr_i,
   input  logic            pop_i,
   output fetch_entry_t    head_o,
   output logic [AW:0]     count_o,
   output logic [AW:0]     pending_o
);

   fetch_entry_t    r_mem [DEPTH];
   logic [AW-1:0]   r_head;
   logic [AW-1:0]   r_tail;
   logic [AW:0]     r_count;
   logic [AW:0]     r_pend;
   logic [AW-1:0]   w_fill_idx;

   // Responses return in order, so pending entries are always the youngest ones:
   // the oldest pending entry sits just past the completed ones at the head.
   assign w_fill_idx = r_head + AW'(r_count - r_pend);

   always_ff @(posedge clk_i) begin
      if (rst_i || clear_i) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
         r_pend  <= '0;
      end else begin
         if (push_i) begin
            r_mem[r_tail] <= '{pc: push_pc_i, instr: '0, done: 1'b0};
            r_tail        <= r_tail + AW'(1);
         end
         if (fill_i) begin
            r_mem[w_fill_idx].instr <= fill_instr_i;
            r_mem[w_fill_idx].done  <= 1'b1;
         end
         if (pop_i) begin
            r_head <= r_head + AW'(1);
         end
         r_count <= r_count + (AW+1)'(push_i) - (AW+1)'(pop_i);
         r_pend  <= r_pend  + (AW+1)'(push_i) - (AW+1)'(fill_i);
      end
   end

   assign head_o    = r_mem[r_head];
   assign count_o   = r_count;
   assign pending_o = r_pend;

endmodule

`default_nettype wire

// File: rtl/if_fetch_stage.sv
// ============================================================================
// Module   : if_fetch_stage
// Brief    : Instruction fetch stage: PC register, in-order imem requests, response
//            drop counting after redirects, and the {pc, instr} output to IF/ID.
// Revision : 1.0
// ============================================================================
`default_nettype none

module if_fetch_stage
   import if_pkg::*;
#(
   parameter int         W        = 32,
   parameter int         DEPTH    = 2,
   parameter logic [W-1:0] RESET_PC = '0
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         stall_i,
   input  logic         redirect_i,
   input  logic [W-1:0] redirect_pc_i,
   output logic         imem_req_valid_o,
   input  logic         imem_req_ready_i,
   output logic [W-1:0] imem_addr_o,
   input  logic         imem_rsp_valid_i,
   input  logic [W-1:0] imem_rsp_data_i,
   output logic [W-1:0] pc_o,
   output logic [W-1:0] instr_o,
   output logic         valid_o,
   output logic         flush_o
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]   r_pc;
   logic [AW:0]    r_drop;
   logic [AW:0]    w_count;
   logic [AW:0]    w_pend;
   logic [AW+1:0]  w_inflight;
   logic [AW+1:0]  w_outstanding;
   fetch_entry_t   w_head;
   logic           w_req;
   logic           w_accept;
   logic           w_fill;
   logic           w_pop;
   logic           w_valid;

   // Queue slots plus stale in-flight requests share the DEPTH budget, which keeps
   // drop_cnt bounded by DEPTH. Decision uses pre-pop occupancy.
   assign w_inflight    = (AW+2)'(w_count) + (AW+2)'(r_drop);
   assign w_outstanding = (AW+2)'(w_pend) + (AW+2)'(r_drop);
   assign w_req         = !rst_i && !redirect_i && (w_inflight < (AW+2)'(DEPTH));
   assign w_accept      = w_req && imem_req_ready_i;
   assign w_fill        = imem_rsp_valid_i && (r_drop == '0) && !redirect_i;
   assign w_valid       = (w_count != '0) && w_head.done;
   assign w_pop         = w_valid && !stall_i && !redirect_i;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_pc   <= RESET_PC;
         r_drop <= '0;
      end else if (redirect_i) begin
         r_pc   <= redirect_pc_i & ~W'(3);
         r_drop <= r_drop + w_pend - (AW+1)'(imem_rsp_valid_i);
      end else begin
         if (w_accept) begin
            r_pc <= r_pc + W'(4);
         end
         if (imem_rsp_valid_i && (r_drop != '0)) begin
            r_drop <= r_drop - (AW+1)'(1);
         end
      end
   end

   fetch_queue #(
      .DEPTH (DEPTH)
   ) u_queue (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .clear_i      (redirect_i),
      .push_i       (w_accept),
      .push_pc_i    (r_pc),
      .fill_i       (w_fill),
      .fill_instr_i (imem_rsp_data_i),
      .pop_i        (w_pop),
      .head_o       (w_head),
      .count_o      (w_count),
      .pending_o    (w_pend)
   );

   assign imem_req_valid_o = w_req;
   assign imem_addr_o      = r_pc;
   assign valid_o          = w_valid;
   assign pc_o             = w_valid ? w_head.pc : '0;
   assign instr_o          = w_valid ? w_head.instr : NOP_INSTR;
   assign flush_o          = redirect_i && !rst_i;

   a_rsp_outstanding : assert property (@(posedge clk_i) disable iff (rst_i)
      imem_rsp_valid_i |-> (w_outstanding != '0));
   a_drop_bound : assert property (@(posedge clk_i) disable iff (rst_i)
      r_drop <= (AW+1)'(DEPTH));

endmodule

`default_nettype wire

// File: tb/tb_if_fetch_stage.sv
// ============================================================================
// Module   : tb_if_fetch_stage
// Brief    : Directed vector table plus randomized run against a queue-based model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_if_fetch_stage;

   localparam int          DEPTH = 4;
   localparam logic [31:0] RPC   = 32'h0000_0100;
   localparam logic [31:0] NOP   = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst, stall, redirect, ready, rsp_valid;
   logic [31:0] redirect_pc, rsp_data;
   logic        req_valid, valid, flush;
   logic [31:0] addr, pc, instr;

   always #5 clk = ~clk;

   if_fetch_stage #(.W(32), .DEPTH(DEPTH), .RESET_PC(RPC)) dut (
      .clk_i            (clk),
      .rst_i            (rst),
      .stall_i          (stall),
      .redirect_i       (redirect),
      .redirect_pc_i    (redirect_pc),
      .imem_req_valid_o (req_valid),
      .imem_req_ready_i (ready),
      .imem_addr_o      (addr),
      .imem_rsp_valid_i (rsp_valid),
      .imem_rsp_data_i  (rsp_data),
      .pc_o             (pc),
      .instr_o          (instr),
      .valid_o          (valid),
      .flush_o          (flush)
   );

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] imem(input logic [31:0] a);
      return (a * 32'd2654435761) ^ 32'h0000_1357;
   endfunction

   typedef struct {
      logic        stall, redir;
      logic [31:0] rpc;
      logic        rdy, rsp;
      logic [31:0] rdata;
      logic        ereq;
      logic [31:0] eaddr;
      logic        ev;
      logic [31:0] epc, einstr;
      logic        efl;
   } vec_t;
   vec_t vecs[$];

   task automatic addv(input logic s, input logic r, input logic [31:0] rp, input logic rdy,
                       input logic rv, input logic [31:0] rd, input logic eq,
                       input logic [31:0] ea, input logic ev, input logic [31:0] ep,
                       input logic [31:0] ei, input logic ef);
      vecs.push_back('{s, r, rp, rdy, rv, rd, eq, ea, ev, ep, ei, ef});
   endtask

   typedef struct {
      logic [31:0] pc, instr;
      bit          done;
   } ment_t;
   ment_t       m_q[$];
   logic [31:0] mem_q[$];
   logic [31:0] m_pc, exp_next;
   int          m_drop;

   initial begin
      rst = 1'b1; stall = 0; redirect = 0; redirect_pc = 0; ready = 0; rsp_valid = 0; rsp_data = 0;

      //   stl red rpc           rdy rsp data           req addr          v  pc            instr         fl
      addv(0, 0, 0,            1, 0, 0,            1, 32'h100,       0, 0,            NOP,          0);
      addv(0, 0, 0,            1, 1, 32'hC0DE0100, 1, 32'h104,       0, 0,            NOP,          0);
      addv(0, 0, 0,            1, 1, 32'hC0DE0104, 1, 32'h108,       1, 32'h100,      32'hC0DE0100, 0);
      addv(1, 0, 0,            1, 1, 32'hC0DE0108, 1, 32'h10C,       1, 32'h104,      32'hC0DE0104, 0);
      addv(1, 0, 0,            1, 1, 32'hC0DE010C, 1, 32'h110,       1, 32'h104,      32'hC0DE0104, 0);
      addv(1, 0, 0,            1, 1, 32'hC0DE0110, 0, 32'h114,       1, 32'h104,      32'hC0DE0104, 0);
      addv(0, 0, 0,            1, 0, 0,            0, 32'h114,       1, 32'h104,      32'hC0DE0104, 0);
      addv(0, 0, 0,            0, 0, 0,            1, 32'h114,       1, 32'h108,      32'hC0DE0108, 0);
      addv(0, 0, 0,            0, 0, 0,            1, 32'h114,       1, 32'h10C,      32'hC0DE010C, 0);
      addv(0, 0, 0,            1, 0, 0,            1, 32'h114,       1, 32'h110,      32'hC0DE0110, 0);
      addv(0, 0, 0,            1, 0, 0,            1, 32'h118,       0, 0,            NOP,          0);
      addv(0, 1, 32'h2002,     1, 0, 0,            0, 32'h11C,       0, 0,            NOP,          1);
      addv(0, 0, 0,            1, 1, 32'hDEAD0114, 1, 32'h2000,      0, 0,            NOP,          0);
      addv(0, 0, 0,            1, 1, 32'hDEAD0118, 1, 32'h2004,      0, 0,            NOP,          0);
      addv(0, 0, 0,            0, 1, 32'hC0DE2000, 1, 32'h2008,      0, 0,            NOP,          0);
      addv(0, 0, 0,            0, 0, 0,            1, 32'h2008,      1, 32'h2000,     32'hC0DE2000, 0);
      addv(0, 1, 32'h3000,     1, 1, 32'hC0DE2004, 0, 32'h2008,      0, 0,            NOP,          1);
      addv(0, 0, 0,            1, 0, 0,            1, 32'h3000,      0, 0,            NOP,          0);
      addv(0, 0, 0,            0, 1, 32'hC0DE3000, 1, 32'h3004,      0, 0,            NOP,          0);
      addv(0, 0, 0,            0, 0, 0,            1, 32'h3004,      1, 32'h3000,     32'hC0DE3000, 0);
      addv(0, 1, 32'h010C,     1, 0, 0,            0, 32'h3004,      0, 0,            NOP,          1);
      for (int i = 0; i < 4; i++)
         addv(0, 0, 0,         0, 0, 0,            1, 32'h10C,       0, 0,            NOP,          0);
      addv(0, 0, 0,            1, 0, 0,            1, 32'h10C,       0, 0,            NOP,          0);
      addv(0, 1, 32'hFFFFFFFF, 1, 0, 0,            0, 32'h110,       0, 0,            NOP,          1);
      addv(0, 0, 0,            1, 1, 32'hDEAD010C, 1, 32'hFFFFFFFC,  0, 0,            NOP,          0);
      addv(0, 0, 0,            1, 1, 32'hC0DEFFFC, 1, 32'h0,         0, 0,            NOP,          0);
      addv(0, 0, 0,            0, 1, 32'hC0DE0000, 1, 32'h4,         1, 32'hFFFFFFFC, 32'hC0DEFFFC, 0);
      addv(0, 0, 0,            0, 0, 0,            1, 32'h4,         1, 32'h0,        32'hC0DE0000, 0);

      @(negedge clk); #2;
      chk("reset_req_valid", {31'b0, req_valid}, 32'd0);
      chk("reset_valid",     {31'b0, valid},     32'd0);
      chk("reset_instr",     instr,              NOP);
      chk("reset_pc",        pc,                 32'd0);
      chk("reset_flush",     {31'b0, flush},     32'd0);

      foreach (vecs[i]) begin
         @(negedge clk);
         rst = 1'b0;
         stall = vecs[i].stall; redirect = vecs[i].redir; redirect_pc = vecs[i].rpc;
         ready = vecs[i].rdy; rsp_valid = vecs[i].rsp; rsp_data = vecs[i].rdata;
         #2;
         chk($sformatf("v%0d_req", i),   {31'b0, req_valid}, {31'b0, vecs[i].ereq});
         chk($sformatf("v%0d_addr", i),  addr,  vecs[i].eaddr);
         chk($sformatf("v%0d_valid", i), {31'b0, valid}, {31'b0, vecs[i].ev});
         chk($sformatf("v%0d_pc", i),    pc,    vecs[i].epc);
         chk($sformatf("v%0d_instr", i), instr, vecs[i].einstr);
         chk($sformatf("v%0d_flush", i), {31'b0, flush}, {31'b0, vecs[i].efl});
      end

      // Mid-run reset, then randomized traffic against the reference model.
      @(negedge clk);
      rst = 1'b1; stall = 0; redirect = 0; ready = 1; rsp_valid = 0;
      #2;
      chk("midreset_req_valid", {31'b0, req_valid}, 32'd0);
      m_pc = RPC; exp_next = RPC; m_drop = 0; m_q.delete(); mem_q.delete();

      for (int c = 0; c < 10000; c++) begin
         logic        e_req, e_valid, e_pop, acc;
         logic [31:0] e_pc, e_instr;
         int          pend;
         @(negedge clk);
         rst         = 1'b0;
         stall       = ($urandom_range(3) == 0);
         redirect    = ($urandom_range(15) == 0);
         redirect_pc = $urandom;
         ready       = ($urandom_range(3) != 0);
         rsp_valid   = (mem_q.size() > 0) && ($urandom_range(2) != 0);
         rsp_data    = rsp_valid ? imem(mem_q[0]) : $urandom;
         #2;
         e_req   = !redirect && (m_q.size() + m_drop < DEPTH);
         e_valid = (m_q.size() > 0) && m_q[0].done;
         e_pc    = e_valid ? m_q[0].pc : 32'd0;
         e_instr = e_valid ? m_q[0].instr : NOP;
         e_pop   = e_valid && !stall && !redirect;
         chk("rnd_req", {31'b0, req_valid}, {31'b0, e_req});
         if (e_req) chk("rnd_addr", addr, m_pc);
         chk("rnd_valid", {31'b0, valid}, {31'b0, e_valid});
         chk("rnd_pc", pc, e_pc);
         chk("rnd_instr", instr, e_instr);
         chk("rnd_flush", {31'b0, flush}, {31'b0, redirect});
         if (e_pop) begin
            chk("rnd_order_pc", pc, exp_next);
            chk("rnd_order_instr", instr, imem(exp_next));
            exp_next = exp_next + 32'd4;
         end

         acc = req_valid && ready;
         if (rsp_valid) void'(mem_q.pop_front());
         if (acc) mem_q.push_back(addr);

         if (redirect) begin
            pend = 0;
            foreach (m_q[k]) if (!m_q[k].done) pend++;
            m_drop   = m_drop + pend - (rsp_valid ? 1 : 0);
            m_q.delete();
            m_pc     = redirect_pc & 32'hFFFF_FFFC;
            exp_next = m_pc;
         end else begin
            if (rsp_valid) begin
               if (m_drop > 0) m_drop--;
               else begin
                  for (int k = 0; k < m_q.size(); k++) begin
                     if (!m_q[k].done) begin
                        m_q[k].done  = 1'b1;
                        m_q[k].instr = rsp_data;
                        break;
                     end
                  end
               end
            end
            if (e_pop) void'(m_q.pop_front());
            if (e_req && ready) begin
               m_q.push_back('{m_pc, 32'd0, 1'b0});
               m_pc = m_pc + 32'd4;
            end
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
